// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR MAC sequencer.
// The FSM state enum, default widths, derived accumulator width and the
// sample/coefficient/product typedefs live here.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_FLUSH,
    ST_OUT
  } fir_state_t;

  localparam int unsigned FIR_SAMPLE_W = 16;
  localparam int unsigned FIR_MAX_TAPS = 16;
  localparam int unsigned FIR_PROD_W   = 2 * FIR_SAMPLE_W;

  // Wide enough that a sum of FIR_MAX_TAPS full-scale products cannot overflow.
  localparam int unsigned FIR_ACC_W    = FIR_PROD_W + $clog2(FIR_MAX_TAPS);

  typedef logic signed [FIR_SAMPLE_W-1:0] sample_t;
  typedef logic signed [FIR_SAMPLE_W-1:0] coef_t;
  typedef logic signed [FIR_PROD_W-1:0]   prod_t;
  typedef logic signed [FIR_ACC_W-1:0]    acc_t;

  // Accumulator width for arbitrary sample width and tap count.
  function automatic int unsigned fir_acc_width(input int unsigned sw,
                                                input int unsigned taps);
    return 2 * sw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate datapath: one registered signed product per cycle,
// folded into a clearable accumulator one cycle later.
module fir_mac
  import fir_pkg::*;
#(
  parameter int unsigned C_SAMPLE_WIDTH = FIR_SAMPLE_W,
  parameter int unsigned C_ACC_WIDTH    = FIR_ACC_W
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             in_valid_i,
  input  logic signed [C_SAMPLE_WIDTH-1:0] a_i,
  input  logic signed [C_SAMPLE_WIDTH-1:0] b_i,
  input  logic                             acc_clr_i,
  output logic signed [C_ACC_WIDTH-1:0]    acc_o
);

  localparam int unsigned PW = 2 * C_SAMPLE_WIDTH;

  logic signed [PW-1:0]          prod_d;
  logic signed [PW-1:0]          prod_q;
  logic                          prod_vld_q;
  logic signed [C_ACC_WIDTH-1:0] acc_d;
  logic signed [C_ACC_WIDTH-1:0] acc_q;

  // Full-precision signed product of the current tap operands.
  always_comb begin
    prod_d = PW'(a_i) * PW'(b_i);
  end

  // Accumulator next value: clear wins over accumulation.
  always_comb begin
    acc_d = acc_q;
    if (acc_clr_i) begin
      acc_d = '0;
    end else if (prod_vld_q) begin
      acc_d = acc_q + C_ACC_WIDTH'(prod_q);
    end
  end

  // Product pipeline register and accumulator state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      if (in_valid_i) begin
        prod_q <= prod_d;
      end
      prod_vld_q <= in_valid_i;
      acc_q      <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR filter: one shared multiplier walks the active taps
// over a circular sample history, then presents the result on a
// valid/ready output.
// Optional feature: define FIR_SEQ_SAT_EN to saturate the result to the
// signed output range instead of wrapping.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned C_MAX_TAPS     = 16,
  parameter int unsigned C_SAMPLE_WIDTH = 16,
  parameter int unsigned C_OUT_WIDTH    = 32
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [$clog2(C_MAX_TAPS):0]       cfg_ntaps,
  input  logic                              coef_we,
  input  logic [$clog2(C_MAX_TAPS)-1:0]     coef_addr,
  input  logic signed [C_SAMPLE_WIDTH-1:0]  coef_wdata,
  output logic                              coef_err,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic signed [C_SAMPLE_WIDTH-1:0]  s_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [C_OUT_WIDTH-1:0]            m_data,
  output logic                              busy
);

  localparam int unsigned LW = $clog2(C_MAX_TAPS);
  localparam int unsigned NW = LW + 1;
  localparam int unsigned SW = C_SAMPLE_WIDTH;
  localparam int unsigned OW = C_OUT_WIDTH;
  localparam int unsigned AW = fir_acc_width(C_SAMPLE_WIDTH, C_MAX_TAPS);

  fir_state_t state_q, state_d;

  logic [LW-1:0]        wptr_q;
  logic [LW-1:0]        base_q;
  logic [NW-1:0]        ntaps_q;
  logic [NW-1:0]        ntaps_clamped;
  logic [NW-1:0]        tap_q;
  logic signed [SW-1:0] hist_q [C_MAX_TAPS];
  logic signed [SW-1:0] coef_q [C_MAX_TAPS];

  logic                 coef_err_q;
  logic                 m_valid_q;
  logic [OW-1:0]        m_data_q;

  logic                 accept;
  logic                 mac_issue;
  logic                 out_load;
  logic                 out_fire;
  logic                 last_tap;

  logic [LW-1:0]        rd_idx;
  logic signed [SW-1:0] mul_a;
  logic signed [SW-1:0] mul_b;
  logic signed [AW-1:0] acc;
  logic [OW-1:0]        result;

  // Map the requested tap count into 1..C_MAX_TAPS.
  always_comb begin
    ntaps_clamped = cfg_ntaps;
    if (cfg_ntaps == '0) begin
      ntaps_clamped = NW'(1);
    end else if (cfg_ntaps > NW'(C_MAX_TAPS)) begin
      ntaps_clamped = NW'(C_MAX_TAPS);
    end
  end

  assign last_tap = (tap_q == ntaps_q - NW'(1));

  // FSM state register.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)   state_d = ST_MAC;
      ST_MAC:   if (last_tap) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_OUT;
      ST_OUT:   if (out_fire) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath control strobes.
  // The result register is loaded on the first OUT cycle, after the FLUSH
  // edge has folded the last product into the accumulator.
  always_comb begin
    s_ready   = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    accept    = s_valid && (state_q == ST_IDLE);
    mac_issue = (state_q == ST_MAC);
    out_load  = (state_q == ST_OUT) && !m_valid_q;
    out_fire  = m_valid_q && m_ready;
  end

  // Write pointer, pass-local base pointer, latched tap count, tap counter.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wptr_q  <= '0;
      base_q  <= '0;
      ntaps_q <= NW'(1);
      tap_q   <= '0;
    end else if (accept) begin
      wptr_q  <= wptr_q + LW'(1);
      base_q  <= wptr_q;
      ntaps_q <= ntaps_clamped;
      tap_q   <= '0;
    end else if (mac_issue) begin
      tap_q   <= tap_q + NW'(1);
    end
  end

  // Sample history and coefficient storage; writes only while idle.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      for (int unsigned i = 0; i < C_MAX_TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        hist_q[wptr_q] <= s_data;
      end
      if (coef_we && (state_q == ST_IDLE)) begin
        coef_q[coef_addr] <= coef_wdata;
      end
    end
  end

  // One-cycle error pulse for coefficient writes outside IDLE.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      coef_err_q <= 1'b0;
    end else begin
      coef_err_q <= coef_we && (state_q != ST_IDLE);
    end
  end

  // Tap k reads the sample written k acceptances before this one.
  always_comb begin
    rd_idx = base_q - tap_q[LW-1:0];
    mul_a  = hist_q[rd_idx];
    mul_b  = coef_q[tap_q[LW-1:0]];
  end

  fir_mac #(
    .C_SAMPLE_WIDTH (SW),
    .C_ACC_WIDTH    (AW)
  ) u_mac (
    .clk_i      (s00_axi_aclk),
    .rst_i      (s00_axi_areset),
    .in_valid_i (mac_issue),
    .a_i        (mul_a),
    .b_i        (mul_b),
    .acc_clr_i  (accept),
    .acc_o      (acc)
  );

`ifdef FIR_SEQ_SAT_EN
  localparam int unsigned EW = ((AW > OW) ? AW : OW) + 1;

  logic signed [EW-1:0] acc_ext;
  logic signed [EW-1:0] sat_max;
  logic signed [EW-1:0] sat_min;

  // Clamp the accumulator into the signed output range.
  always_comb begin
    acc_ext          = EW'(acc);
    sat_max          = '0;
    sat_max[OW-2:0]  = '1;
    sat_min          = ~sat_max;
    if (acc_ext > sat_max) begin
      result = OW'(sat_max);
    end else if (acc_ext < sat_min) begin
      result = OW'(sat_min);
    end else begin
      result = OW'(acc_ext);
    end
  end
`else
  // Keep the low output bits of the accumulator (two's-complement wrap).
  always_comb begin
    result = OW'(acc);
  end
`endif

  // Output register: loaded once per pass, held until the consumer accepts.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (out_load) begin
      m_valid_q <= 1'b1;
      m_data_q  <= result;
    end else if (out_fire) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign coef_err = coef_err_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer (default parameters).
// Results are predicted by a plain convolution over a model history.
module tb_fir_mac_sequencer;
  import fir_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [4:0]         cfg_ntaps;
  logic               coef_we;
  logic [3:0]         coef_addr;
  logic signed [15:0] coef_wdata;
  logic               coef_err;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_data;
  logic               m_valid;
  logic               m_ready;
  logic [31:0]        m_data;
  logic               busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  sample_t     mh [16];
  coef_t       mc [16];
  int unsigned mw;

  fir_mac_sequencer #(
    .C_MAX_TAPS     (16),
    .C_SAMPLE_WIDTH (16),
    .C_OUT_WIDTH    (32)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .cfg_ntaps      (cfg_ntaps),
    .coef_we        (coef_we),
    .coef_addr      (coef_addr),
    .coef_wdata     (coef_wdata),
    .coef_err       (coef_err),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input longint s);
    logic [63:0] v;
    v = s;
`ifdef FIR_SEQ_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return v[31:0];
  endfunction

  function automatic int unsigned clamp_taps(input logic [4:0] nt);
    if (nt == 0) return 1;
    if (nt > 16) return 16;
    return int'(nt);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mh[i] = '0;
      mc[i] = '0;
    end
    mw = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  task automatic write_coef(input int unsigned addr, input logic signed [15:0] val);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = addr[3:0];
    coef_wdata = val;
    @(posedge clk);
    #1 coef_we = 1'b0;
    mc[addr] = val;
    check("coef_err_idle", coef_err, 0);
  endtask

  // One full pass: accept, latency, result, optional output stall and an
  // optional rejected coefficient write during MAC.
  task automatic run_sample(input logic signed [15:0] x, input logic [4:0] nt,
                            input int unsigned stall, input bit mid_coef,
                            output logic [31:0] got);
    int unsigned n, w, edges;
    longint      acc;
    logic [31:0] expv, held;

    @(negedge clk);
    check("s_ready_idle", s_ready, 1);
    s_valid   = 1'b1;
    s_data    = x;
    cfg_ntaps = nt;
    m_ready   = (stall == 0);
    @(posedge clk);
    #1;
    s_valid   = 1'b0;
    cfg_ntaps = 5'($urandom_range(0, 31));
    if (mid_coef) begin
      coef_we    = 1'b1;
      coef_addr  = 4'd0;
      coef_wdata = ~mc[0];
    end

    w     = mw;
    mh[w] = x;
    mw    = (mw + 1) % 16;
    n     = clamp_taps(nt);
    acc   = 0;
    for (int k = 0; k < int'(n); k++) begin
      acc += longint'(mc[k]) * longint'(mh[(int'(w) + 16 - k) % 16]);
    end
    expv = fmt(acc);

    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) check("busy_in_pass", busy, 1);
      if (mid_coef && edges == 1) begin
        check("coef_err_pulse", coef_err, 1);
        coef_we = 1'b0;
      end
      if (mid_coef && edges == 2) check("coef_err_single", coef_err, 0);
    end while (!m_valid && edges < 100);

    check("latency", edges, n + 2);
    check("m_data", m_data, expv);
    got = m_data;

    if (stall != 0) begin
      held = m_data;
      for (int i = 0; i < int'(stall); i++) begin
        @(posedge clk);
        #1;
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, held);
        check("stall_s_ready", s_ready, 0);
      end
      m_ready = 1'b1;
    end

    @(posedge clk);
    #1;
    check("m_valid_drop", m_valid, 0);
    check("ready_after", s_ready, 1);
  endtask

  logic [31:0] got;
  logic [31:0] exp_seq [5];
  bit          seen;

  initial begin
    rst        = 1'b1;
    cfg_ntaps  = '0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    m_ready    = 1'b1;
    exp_seq    = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd14};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_m_data", m_data, 0);
    check("rst_coef_err", coef_err, 0);

    // Single tap, identity coefficient
    write_coef(0, 16'sd1);
    run_sample(16'sd85, 5'd1, 0, 1'b0, got);
    check("single_tap_85", got, 32'd85);

    // Four-tap moving sum, then random traffic past the pointer wrap
    do_reset();
    for (int i = 0; i < 4; i++) write_coef(i, 16'sd1);
    for (int i = 0; i < 5; i++) begin
      run_sample(16'(i + 1), 5'd4, 0, 1'b0, got);
      check("moving_sum", got, exp_seq[i]);
    end
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0)
        write_coef($urandom_range(0, 15), 16'($urandom));
      run_sample(16'($urandom), 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1'b0, got);
    end

    // Output back-pressure for 10 cycles
    run_sample(16'($urandom), 5'd6, 10, 1'b0, got);

    // Rejected coefficient write during MAC, then an unaffected pass
    write_coef(0, 16'sd1234);
    run_sample(16'($urandom), 5'd16, 0, 1'b1, got);
    run_sample(16'($urandom), 5'd16, 0, 1'b0, got);

    // Full-scale accumulation over all taps
    do_reset();
    for (int i = 0; i < 16; i++) write_coef(i, 16'sh7FFF);
    for (int i = 0; i < 16; i++) run_sample(16'sh7FFF, 5'd16, 0, 1'b0, got);
`ifdef FIR_SEQ_SAT_EN
    check("full_scale", got, 32'h7FFF_FFFF);
`else
    check("full_scale", got, 32'hFFF0_0010);
`endif

    // Reset in the middle of a pass aborts it
    @(negedge clk);
    s_valid   = 1'b1;
    s_data    = 16'sd100;
    cfg_ntaps = 5'd16;
    @(posedge clk);
    #1 s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (m_valid) seen = 1'b1;
    end
    check("abort_no_valid", seen, 0);
    check("abort_busy", busy, 0);
    check("abort_s_ready", s_ready, 1);
    check("abort_m_data", m_data, 0);

    // Clean operation after abort
    run_sample(16'sd9, 5'd1, 0, 1'b0, got);
    check("post_abort_zero", got, 0);
    write_coef(1, -16'sd3);
    run_sample(16'sd7, 5'd0, 0, 1'b0, got);
    run_sample(16'sd5, 5'd2, 0, 1'b0, got);
    check("post_abort_pair", got, 32'hFFFF_FFEB);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter C_MAX_TAPS, default 16, maximum number of filter taps (power of two).
REQ-002 SHALL have parameter C_SAMPLE_WIDTH, default 16, signed sample and coefficient width.
REQ-003 SHALL have parameter C_OUT_WIDTH, default 32, signed result width.
REQ-004 SHALL use one clock and a synchronous, active-high reset: s00_axi_aclk input 1, rising-edge clock.
REQ-005 s00_axi_areset input 1, synchronous active-high reset.
REQ-006 cfg_ntaps input $clog2(C_MAX_TAPS)+1, active tap count.
REQ-007 coef_we input 1, coefficient write strobe.
REQ-008 coef_addr input $clog2(C_MAX_TAPS), coefficient index.
REQ-009 coef_wdata input C_SAMPLE_WIDTH, signed coefficient.
REQ-010 coef_err output 1, one-cycle pulse when a coefficient write is rejected.
REQ-011 s_valid input 1, s_ready output 1, s_data input C_SAMPLE_WIDTH: sample handshake.
REQ-012 m_valid output 1, m_ready input 1, m_data output C_OUT_WIDTH: result handshake.
REQ-013 busy output 1, high in every state except IDLE.

Function
REQ-014 SHALL compute y[n] = sum over k=0..N-1 of coef[k]*x[n-k], where N is cfg_ntaps latched at sample acceptance.
- N=0 is treated as 1; N>C_MAX_TAPS is clamped to C_MAX_TAPS.
REQ-015 SHALL use one shared multiplier in a time-multiplexed datapath, one tap per cycle.
REQ-016 FSM states SHALL be:
- IDLE -> MAC on s_valid&&s_ready.
- MAC -> FLUSH after N tap cycles.
- FLUSH (1 cycle, multiplier pipeline drain) -> OUT.
- OUT -> IDLE on m_valid&&m_ready.
REQ-017 s_ready SHALL be 1 only in IDLE. On acceptance, the sample SHALL be written to the circular history at wptr, and wptr SHALL increment modulo C_MAX_TAPS (wrap 15->0).
REQ-018 History SHALL be indexed as (wptr_at_accept - k) mod C_MAX_TAPS; unwritten slots read 0.
REQ-019 m_valid SHALL rise exactly N+2 clock edges after the accepting edge.
- While m_valid=1 and m_ready=0, m_valid and m_data SHALL hold stable.
REQ-020 Products SHALL be 2*C_SAMPLE_WIDTH signed; the accumulator SHALL be 2*C_SAMPLE_WIDTH+$clog2(C_MAX_TAPS) bits and SHALL never overflow internally.
REQ-021 Coefficient writes SHALL be accepted only in IDLE.
- A coef_we in any other state SHALL be dropped, and coef_err SHALL pulse on the next cycle.
REQ-022 If coef_we and an accepted sample occur in the same IDLE cycle, the write SHALL take effect before the MAC pass uses that coefficient.
REQ-023 cfg_ntaps changes while busy SHALL NOT affect the pass in progress.

Reset
REQ-024 Reset SHALL force the following; reset asserted in any state SHALL abort the pass with no m_valid:
- State IDLE.
- s_ready=1 on the first cycle after reset release.
- m_valid=0, m_data=0, busy=0, coef_err=0.
- wptr=0; all history and coefficients cleared to 0.

Configuration
REQ-025 With macro FIR_SEQ_SAT_EN defined, m_data SHALL be the accumulator saturated to the signed C_OUT_WIDTH range.
REQ-026 Without FIR_SEQ_SAT_EN, m_data SHALL be the low C_OUT_WIDTH bits of the accumulator (wrap).

Structure
REQ-027 Package fir_pkg SHALL hold the FSM state enum, the accumulator-width constant, and the sample/coef/product typedefs.
REQ-028 The multiply-accumulate datapath SHALL be sub-module fir_mac (registered product, accumulator with clear and enable).
- fir_mac_sequencer SHALL hold the FSM, the history buffer and the coefficient registers.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Reset -> s_ready=1, m_valid=0, busy=0, m_data=0.
- coef[0]=1, others 0, ntaps=1, sample 85 -> m_data=85, m_valid 3 edges after accept.
- ntaps=4, coef[0..3]=1, samples 1,2,3,4,5 -> outputs 1,3,6,10,14; checks wptr wrap after 16+ samples.
- m_ready held 0 for 10 cycles -> m_valid and m_data stable, s_ready=0; the output completes on m_ready=1.
- coef_we during MAC -> coef_err single pulse, coefficient unchanged, next result unaffected.
- ntaps=16, all coefs and samples 0x7FFF -> with FIR_SEQ_SAT_EN m_data=0x7FFFFFFF; without it m_data=0xFFF00010; plus reset mid-MAC -> no m_valid, state IDLE.
